// File: rtl/wb_pkg.sv
// Shared types and widths for the data-bus Wishbone initiator.
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = 4;

  // IDLE: ready for a core request. BUS: a Wishbone cycle is outstanding.
  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_e;

endpackage : wb_pkg

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog counter. It is held at zero while clr_i is high and
// counts while en_i is high. expired_o flags the TIMEOUT_CYCLES-th enabled
// cycle, so an initiator that aborts on it keeps cyc high for exactly
// TIMEOUT_CYCLES cycles.
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Flag the final allowed cycle while the counter is running.
  assign expired_o = en_i && (cnt_q == LAST);

  // Next count: clear wins; stop at the limit so the value never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !expired_o)
      cnt_d = cnt_q + 1'b1;
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule : wb_timeout_ctr

// File: rtl/wb_dbus_master.sv
// Wishbone classic single-beat initiator between the core LSU and the uncore
// decoder. One transfer at a time; every Wishbone output is registered.
// Optional watchdog: define WB_DBUS_MASTER_TIMEOUT_EN to abort cycles that are
// not acknowledged within TIMEOUT_CYCLES and return rsp_err_o = 1.
module wb_dbus_master
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [WB_ADDR_W-1:0] req_addr_i,
  input  logic [WB_DATA_W-1:0] req_wdata_i,
  input  logic [WB_SEL_W-1:0]  req_sel_i,
  output logic                 rsp_valid_o,
  output logic [WB_DATA_W-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [WB_ADDR_W-1:0] wb_adr_o,
  output logic [WB_DATA_W-1:0] wb_dat_o,
  output logic [WB_SEL_W-1:0]  wb_sel_o,
  input  logic [WB_DATA_W-1:0] wb_dat_i,
  input  logic                 wb_ack_i
);

  state_e               state_q, state_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [WB_ADDR_W-1:0] adr_q, adr_d;
  logic [WB_DATA_W-1:0] dat_q, dat_d;
  logic [WB_SEL_W-1:0]  sel_q, sel_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 timeout_hit;

`ifdef WB_DBUS_MASTER_TIMEOUT_EN
  // Watchdog: held clear while idle, counts every BUS cycle.
  wb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_i),
    .clr_i     (state_q == IDLE),
    .en_i      (state_q == BUS),
    .expired_o (timeout_hit)
  );
`else
  // Without the watchdog a cycle waits for its ack indefinitely.
  assign timeout_hit = 1'b0;
`endif

  // Ready depends on state alone, so it never loops back through the core.
  assign req_ready_o = (state_q == IDLE);

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;  // single-beat: stb always follows cyc
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  // Next-state and next-output logic for the two-state transfer FSM.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // Request fields are captured only here and held for the whole cycle.
        if (req_valid_i) begin
          we_d    = req_we_i;
          adr_d   = req_addr_i;
          dat_d   = req_wdata_i;
          sel_d   = req_sel_i;
          cyc_d   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack has priority over expiry when both land in the same cycle.
        if (wb_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : wb_dat_i;
          state_d     = IDLE;
        end else if (timeout_hit) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule : wb_dbus_master

// File: tb/tb_wb_dbus_master.sv
// Directed bench for wb_dbus_master. Inputs change 1 ns after the rising
// edge and outputs are sampled at that same point, away from the edge.
// Watchdog cases are compiled when WB_DBUS_MASTER_TIMEOUT_EN is defined.
module tb_wb_dbus_master;

  localparam int unsigned TMO       = 8;
  localparam logic [31:0] DAT_XOR_K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_ack;

  // Slave model: optional zero-wait ack and optional address-derived data.
  logic        zero_wait, ack_man, dat_from_adr;
  logic [31:0] dat_man;
  assign wb_ack   = (zero_wait & wb_cyc & wb_stb) | ack_man;
  assign wb_dat_i = dat_from_adr ? (wb_adr ^ DAT_XOR_K) : dat_man;

  int n_checks = 0;
  int n_fail   = 0;

  wb_dbus_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_sel_i   (req_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .wb_cyc_o    (wb_cyc),
    .wb_stb_o    (wb_stb),
    .wb_we_o     (wb_we),
    .wb_adr_o    (wb_adr),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle-side view: no cycle, no response, ready high.
  task automatic check_idle(input string tag);
    check({tag, " cyc"},   32'(wb_cyc),    32'd0);
    check({tag, " stb"},   32'(wb_stb),    32'd0);
    check({tag, " rsp"},   32'(rsp_valid), 32'd0);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
  endtask

  // Cycle in flight with the given attributes and no response yet.
  task automatic check_bus(input string tag, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
    check({tag, " cyc"},   32'(wb_cyc),    32'd1);
    check({tag, " stb"},   32'(wb_stb),    32'd1);
    check({tag, " we"},    32'(wb_we),     32'(we));
    check({tag, " adr"},   wb_adr,         adr);
    check({tag, " dat"},   wb_dat_o,       dat);
    check({tag, " sel"},   32'(wb_sel),    32'(sel));
    check({tag, " ready"}, 32'(req_ready), 32'd0);
    check({tag, " rsp"},   32'(rsp_valid), 32'd0);
  endtask

  // Response pulse cycle: cyc already low, ready back high.
  task automatic check_rsp(input string tag, input logic [31:0] rdata, input logic err);
    check({tag, " rsp"},   32'(rsp_valid), 32'd1);
    check({tag, " rdata"}, rsp_rdata,      rdata);
    check({tag, " err"},   32'(rsp_err),   32'(err));
    check({tag, " cyc"},   32'(wb_cyc),    32'd0);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic issue(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = adr;
    req_wdata = dat;
    req_sel   = sel;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] bb_adr [3];
    bb_adr[0] = 32'h1000_0010;
    bb_adr[1] = 32'h1000_0024;
    bb_adr[2] = 32'h1000_0038;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_sel = '0; zero_wait = 1'b0; ack_man = 1'b0;
    dat_from_adr = 1'b0; dat_man = '0;

    // Reset values.
    tick(); tick();
    check_idle("reset");
    check("reset we",    32'(wb_we),   32'd0);
    check("reset adr",   wb_adr,       32'd0);
    check("reset dat",   wb_dat_o,     32'd0);
    check("reset sel",   32'(wb_sel),  32'd0);
    check("reset err",   32'(rsp_err), 32'd0);
    check("reset rdata", rsp_rdata,    32'd0);
    rst_n = 1'b1;
    tick();

    // Read with zero-wait slave: one BUS cycle, response next cycle.
    zero_wait = 1'b1; dat_man = 32'hDEADBEEF;
    issue(1'b0, 32'h0200_BFF8, 32'h0, 4'hF);
    check("rd0 ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check_bus("rd0 bus", 1'b0, 32'h0200_BFF8, 32'h0, 4'hF);
    tick();
    check_rsp("rd0", 32'hDEADBEEF, 1'b0);
    tick();
    check_idle("rd0 after");

    // Write with 3 wait states; request inputs change after acceptance.
    zero_wait = 1'b0; dat_man = 32'hCAFEF00D;
    issue(1'b1, 32'h2000_0C00, 32'h1234_5678, 4'hF);
    tick();
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'hFFFF_FFFF;
    req_wdata = 32'h0; req_sel = 4'h1;
    for (int k = 1; k <= 4; k++) begin
      check_bus($sformatf("wr bus%0d", k), 1'b1, 32'h2000_0C00, 32'h1234_5678, 4'hF);
      if (k == 4) ack_man = 1'b1;
      tick();
    end
    ack_man = 1'b0;
    check_rsp("wr", 32'h0, 1'b0);

    // Three back-to-back reads with req_valid held: a response every 2 cycles.
    zero_wait = 1'b1; dat_from_adr = 1'b1;
    issue(1'b0, bb_adr[0], 32'h0, 4'h3);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_bus($sformatf("bb%0d bus", i), 1'b0, bb_adr[i], 32'h0, 4'h3);
      if (i < 2) req_addr = bb_adr[i+1];
      else       req_valid = 1'b0;
      tick();
      check_rsp($sformatf("bb%0d", i), bb_adr[i] ^ DAT_XOR_K, 1'b0);
      tick();
    end
    check_idle("bb after");
    dat_from_adr = 1'b0;

`ifdef WB_DBUS_MASTER_TIMEOUT_EN
    // No ack: cyc high for TMO cycles, then an error response.
    zero_wait = 1'b0; dat_man = 32'h5555_AAAA;
    issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= int'(TMO); k++) begin
      check($sformatf("tmo cyc%0d", k), 32'(wb_cyc), 32'd1);
      tick();
    end
    check_rsp("tmo", 32'h0, 1'b1);
    tick();

    // Ack on the expiry cycle wins: normal read response.
    issue(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= int'(TMO); k++) begin
      check($sformatf("tmoack cyc%0d", k), 32'(wb_cyc), 32'd1);
      if (k == int'(TMO)) ack_man = 1'b1;
      tick();
    end
    ack_man = 1'b0;
    check_rsp("tmoack", 32'h5555_AAAA, 1'b0);
    tick();
`else
    // Without the watchdog a cycle outlives any timeout and never errors.
    zero_wait = 1'b0; dat_man = 32'h5555_AAAA;
    issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 3 * int'(TMO); k++) begin
      check($sformatf("notmo cyc%0d", k), 32'(wb_cyc), 32'd1);
      check($sformatf("notmo rsp%0d", k), 32'(rsp_valid), 32'd0);
      if (k == 3 * int'(TMO)) ack_man = 1'b1;
      tick();
    end
    ack_man = 1'b0;
    check_rsp("notmo", 32'h5555_AAAA, 1'b0);
    tick();
`endif

    // Reset during BUS: cycle dropped at the next edge, no response.
    zero_wait = 1'b0;
    issue(1'b1, 32'h4000_0000, 32'h0BAD_0BAD, 4'hC);
    tick();
    req_valid = 1'b0;
    check_bus("rstbus", 1'b1, 32'h4000_0000, 32'h0BAD_0BAD, 4'hC);
    tick();
    rst_n = 1'b0;
    tick();
    check_idle("rstbus in reset");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_idle($sformatf("rstbus post%0d", k));
    end

    // Spurious ack while idle: nothing happens.
    ack_man = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_idle($sformatf("spur%0d", k));
    end
    ack_man = 1'b0;

    // First transfer after reset completes normally.
    zero_wait = 1'b1; dat_man = 32'h0F0F_1234;
    issue(1'b0, 32'h4000_0008, 32'h0, 4'hF);
    tick();
    req_valid = 1'b0;
    check_bus("post rst bus", 1'b0, 32'h4000_0008, 32'h0, 4'hF);
    tick();
    check_rsp("post rst", 32'h0F0F_1234, 1'b0);
    tick();
    check_idle("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_wb_dbus_master
